// File: rtl/drift_session_ctrl.sv
// drift_session_ctrl: sequences one drift scoring run (IDLE -> ARM countdown -> RUN window
// -> HOLD result) and drives the main counter and display multiplexer select.
//
// Ports:
//   i_clk          system clock (50 MHz)
//   i_rst          asynchronous active-low reset
//   i_start_stop   raw start/stop switch, asynchronous to i_clk
//   i_range_disp   request to display min range
//   i_speed_disp   request to display max speed
//   i_score        live count from the main counter
//   o_cnt_en       main counter enable, high for every RUN cycle
//   o_cnt_clr      one-cycle main counter clear on ARM entry
//   o_disp_sel     display select: 00 score, 01 range, 10 speed, 11 best
//   o_state        current state: 0 IDLE, 1 ARM, 2 RUN, 3 HOLD
//   o_run_done     one-cycle pulse on HOLD entry
//   o_best         best score since reset
//
// Optional feature: define BEST_SCORE_EN to track the best score and enable the 11 display
// select. Without it o_best is tied to 0 and both switches select range.
module drift_session_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 500000,
  parameter int unsigned ARM_CYCLES       = 150000000,
  parameter int unsigned RUN_LIMIT_CYCLES = 1500000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_stop,
  input  logic        i_range_disp,
  input  logic        i_speed_disp,
  input  logic [31:0] i_score,
  output logic        o_cnt_en,
  output logic        o_cnt_clr,
  output logic [1:0]  o_disp_sel,
  output logic [2:0]  o_state,
  output logic        o_run_done,
  output logic [31:0] o_best
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]    ArmLast = 32'(ARM_CYCLES - 1);
  localparam logic [31:0]    RunLast = 32'(RUN_LIMIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArm  = 3'd1,
    StRun  = 3'd2,
    StHold = 3'd3
  } state_e;

  // ---------------------------------------------------------------------------------------
  // Input conditioning: 2-FF synchroniser, debouncer, edge pulses
  // ---------------------------------------------------------------------------------------
  logic           r_sync1;
  logic           r_sync2;
  logic           r_cand;      // value currently being qualified
  logic [DbW-1:0] r_db_cnt;    // consecutive samples equal to r_cand
  logic           r_db;
  logic           r_db_prev;
  logic           r_seen_low;  // debouncer has accepted a 0 since reset

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_cand     <= 1'b0;
      r_db_cnt   <= '0;
      r_db       <= 1'b0;
      r_db_prev  <= 1'b0;
      r_seen_low <= 1'b0;
    end else begin
      r_sync1   <= i_start_stop;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      if (r_sync2 != r_cand) begin
        // New value: this sample is the first of the stable run.
        r_cand   <= r_sync2;
        r_db_cnt <= DbW'(1);
      end else if (r_db_cnt >= DbLast) begin
        // Counter holds here; keep re-accepting the stable value.
        r_db <= r_cand;
        if (!r_cand) begin
          r_seen_low <= 1'b1;
        end
      end else begin
        r_db_cnt <= r_db_cnt + DbW'(1);
      end
    end
  end

  logic w_rise;
  logic w_fall;

  // A switch held high through reset never reaches seen_low, so it cannot start a run.
  assign w_rise = r_db & ~r_db_prev & r_seen_low;
  assign w_fall = ~r_db & r_db_prev;

  // ---------------------------------------------------------------------------------------
  // Display request decode
  // ---------------------------------------------------------------------------------------
  function automatic logic [1:0] f_disp(input logic rng, input logic spd);
`ifdef BEST_SCORE_EN
    if (rng && spd) return 2'b11;
`endif
    if (rng) return 2'b01;
    if (spd) return 2'b10;
    return 2'b00;
  endfunction

  logic [1:0] w_disp_req;
  assign w_disp_req = f_disp(i_range_disp, i_speed_disp);

  // ---------------------------------------------------------------------------------------
  // Session FSM; every output is a flop loaded with its value for the next state
  // ---------------------------------------------------------------------------------------
  state_e      r_state;
  logic [31:0] r_arm_cnt;
  logic [31:0] r_run_cnt;
  logic        r_cnt_en;
  logic        r_cnt_clr;
  logic        r_run_done;
  logic [1:0]  r_disp_sel;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= StIdle;
      r_arm_cnt  <= '0;
      r_run_cnt  <= '0;
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_run_done <= 1'b0;
      r_disp_sel <= 2'b00;
    end else begin
      r_cnt_clr  <= 1'b0;
      r_run_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_rise) begin
            r_state    <= StArm;
            r_cnt_clr  <= 1'b1;
            r_arm_cnt  <= '0;
            r_disp_sel <= 2'b00;
          end else begin
            r_disp_sel <= w_disp_req;
          end
        end
        StArm: begin
          if (w_fall) begin
            r_state    <= StIdle;
            r_disp_sel <= w_disp_req;
          end else if (r_arm_cnt >= ArmLast) begin
            r_state   <= StRun;
            r_cnt_en  <= 1'b1;
            r_run_cnt <= '0;
          end else begin
            r_arm_cnt <= r_arm_cnt + 32'd1;
          end
        end
        StRun: begin
          // A fall coinciding with the limit still gives a single exit and pulse.
          if (w_fall || (r_run_cnt >= RunLast)) begin
            r_state    <= StHold;
            r_cnt_en   <= 1'b0;
            r_run_done <= 1'b1;
            r_disp_sel <= w_disp_req;
          end else begin
            r_run_cnt <= r_run_cnt + 32'd1;
          end
        end
        StHold: begin
          if (w_rise) begin
            r_state    <= StArm;
            r_cnt_clr  <= 1'b1;
            r_arm_cnt  <= '0;
            r_disp_sel <= 2'b00;
          end else begin
            r_disp_sel <= w_disp_req;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_cnt_en   <= 1'b0;
          r_disp_sel <= 2'b00;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_cnt_en   = r_cnt_en;
  assign o_cnt_clr  = r_cnt_clr;
  assign o_run_done = r_run_done;
  assign o_disp_sel = r_disp_sel;

  // ---------------------------------------------------------------------------------------
  // Best score
  // ---------------------------------------------------------------------------------------
`ifdef BEST_SCORE_EN
  logic [31:0] r_best;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_best <= '0;
    end else if (r_run_done && (i_score > r_best)) begin
      r_best <= i_score;
    end
  end

  assign o_best = r_best;
`else
  logic w_unused_score;
  assign w_unused_score = ^i_score;
  assign o_best         = '0;
`endif

endmodule

// File: tb/tb_drift_session_ctrl.sv
// tb_drift_session_ctrl: directed bench for drift_session_ctrl with small timing parameters
// (debounce 4, arm 8, run limit 20). Table-driven display and best-score vectors plus
// hand-written sequences for bounce, run limit, early stop, abort, coincident stop and reset.
module tb_drift_session_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_start_stop;
  logic        i_range_disp;
  logic        i_speed_disp;
  logic [31:0] i_score;
  logic        o_cnt_en;
  logic        o_cnt_clr;
  logic [1:0]  o_disp_sel;
  logic [2:0]  o_state;
  logic        o_run_done;
  logic [31:0] o_best;

  drift_session_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .ARM_CYCLES      (8),
    .RUN_LIMIT_CYCLES(20)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start_stop(i_start_stop),
    .i_range_disp(i_range_disp),
    .i_speed_disp(i_speed_disp),
    .i_score     (i_score),
    .o_cnt_en    (o_cnt_en),
    .o_cnt_clr   (o_cnt_clr),
    .o_disp_sel  (o_disp_sel),
    .o_state     (o_state),
    .o_run_done  (o_run_done),
    .o_best      (o_best)
  );

`ifdef BEST_SCORE_EN
  localparam logic [1:0] BothSel = 2'b11;
  localparam bit         BestOn  = 1'b1;
`else
  localparam logic [1:0] BothSel = 2'b01;
  localparam bit         BestOn  = 1'b0;
`endif

  typedef struct {
    logic       rng;
    logic       spd;
    logic [1:0] sel;
  } disp_vec_t;

  typedef struct {
    logic [31:0] score;
    logic [31:0] best;
    int          drop_after;  // RUN sample index after which the switch drops, -1 = never
    int          en_lo;
    int          en_hi;
  } run_vec_t;

  disp_vec_t dv[4];
  run_vec_t  rv[4];

  int n_checks = 0;
  int n_errors = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name,
                            output int n);
    n = 0;
    while (o_state !== st && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(o_state), 32'(st));
  endtask

  // Raise the switch, wait for ARM, then measure the ARM window and the clear pulse.
  task automatic do_arm(input string tag, input bit check_lat);
    int n;
    int arm_n;
    int clr_n;
    i_start_stop = 1'b1;
    wait_state(3'd1, 20, {tag, " arm entry"}, n);
    // 2 sync flops + 4 stable samples + 1 FSM cycle
    if (check_lat) chk_range({tag, " arm latency"}, n, 6, 8);
    clr_n = int'(o_cnt_clr);
    arm_n = 0;
    while (o_state == 3'd1 && arm_n < 40) begin
      step();
      arm_n++;
      clr_n += int'(o_cnt_clr);
    end
    chk({tag, " arm cycles"}, 32'(arm_n), 32'd8);
    chk({tag, " clr pulses"}, 32'(clr_n), 32'd1);
    chk({tag, " run entry"}, 32'(o_state), 32'd2);
  endtask

  // From the RUN entry sample, run until HOLD, counting enable cycles and done pulses.
  task automatic do_run(input string tag, input int drop_after, output int en_n);
    int i;
    int done_n;
    en_n = 0;
    i    = 0;
    while (o_state == 3'd2 && i < 40) begin
      en_n += int'(o_cnt_en);
      if (i == drop_after) i_start_stop = 1'b0;
      step();
      i++;
    end
    chk({tag, " hold entry"}, 32'(o_state), 32'd3);
    chk({tag, " en off in hold"}, 32'(o_cnt_en), 32'd0);
    done_n = int'(o_run_done);
    for (int k = 0; k < 5; k++) begin
      step();
      done_n += int'(o_run_done);
    end
    chk({tag, " run_done pulses"}, 32'(done_n), 32'd1);
  endtask

  initial begin
    int bad;
    int n;
    int en_n;
    bit saw_arm;
    int en_seen;

    dv[0] = '{rng: 1'b1, spd: 1'b0, sel: 2'b01};
    dv[1] = '{rng: 1'b0, spd: 1'b1, sel: 2'b10};
    dv[2] = '{rng: 1'b1, spd: 1'b1, sel: BothSel};
    dv[3] = '{rng: 1'b0, spd: 1'b0, sel: 2'b00};

    // Run 0 hits the limit, run 1 stops early, run 2 drops so the debounced fall
    // coincides with timer 19, run 3 hits the limit.
    rv[0] = '{score: 32'd100, best: BestOn ? 32'd100 : 32'd0, drop_after: -1,
              en_lo: 20, en_hi: 20};
    rv[1] = '{score: 32'd50,  best: BestOn ? 32'd100 : 32'd0, drop_after: 5,
              en_lo: 10, en_hi: 14};
    rv[2] = '{score: 32'd100, best: BestOn ? 32'd100 : 32'd0, drop_after: 13,
              en_lo: 20, en_hi: 20};
    rv[3] = '{score: 32'd150, best: BestOn ? 32'd150 : 32'd0, drop_after: -1,
              en_lo: 20, en_hi: 20};

    i_rst        = 1'b0;
    i_start_stop = 1'b0;
    i_range_disp = 1'b0;
    i_speed_disp = 1'b0;
    i_score      = 32'd0;
    repeat (3) step();
    chk("reset state", 32'(o_state), 32'd0);
    chk("reset cnt_en", 32'(o_cnt_en), 32'd0);
    chk("reset cnt_clr", 32'(o_cnt_clr), 32'd0);
    chk("reset run_done", 32'(o_run_done), 32'd0);
    chk("reset disp_sel", 32'(o_disp_sel), 32'd0);
    chk("reset best", o_best, 32'd0);
    i_rst = 1'b1;
    repeat (10) step();

    for (int i = 0; i < 4; i++) begin
      i_range_disp = dv[i].rng;
      i_speed_disp = dv[i].spd;
      step();
      chk($sformatf("idle disp %0d", i), 32'(o_disp_sel), 32'(dv[i].sel));
    end

    // Bounce: toggles every 2 cycles never satisfies 4 stable samples.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      i_start_stop = ((i / 2) % 2) != 0;
      step();
      if (o_state != 3'd0) bad++;
    end
    chk("bounce stays idle", 32'(bad), 32'd0);

    for (int r = 0; r < 4; r++) begin
      i_score = rv[r].score;
      do_arm($sformatf("run%0d", r), r == 0);
      chk($sformatf("run%0d disp in run", r), 32'(o_disp_sel), 32'd0);
      do_run($sformatf("run%0d", r), rv[r].drop_after, en_n);
      chk_range($sformatf("run%0d en cycles", r), en_n, rv[r].en_lo, rv[r].en_hi);
      chk($sformatf("run%0d best", r), o_best, rv[r].best);
      if (r == 0) begin
        // Fall in HOLD is ignored.
        i_start_stop = 1'b0;
        repeat (12) step();
        chk("hold ignores fall", 32'(o_state), 32'd3);
      end
    end

    for (int i = 0; i < 4; i++) begin
      i_range_disp = dv[i].rng;
      i_speed_disp = dv[i].spd;
      step();
      chk($sformatf("hold disp %0d", i), 32'(o_disp_sel), 32'(dv[i].sel));
    end

    // Abort: a short high pulse reaches ARM, the fall returns to IDLE before RUN.
    i_start_stop = 1'b0;
    repeat (12) step();
    i_start_stop = 1'b1;
    repeat (5) step();
    i_start_stop = 1'b0;
    saw_arm = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_state == 3'd1) saw_arm = 1'b1;
      en_seen += int'(o_cnt_en);
    end
    chk("abort saw arm", 32'(saw_arm), 32'd1);
    chk("abort back to idle", 32'(o_state), 32'd0);
    chk("abort en never", 32'(en_seen), 32'd0);

    // Switch held high through reset release must not start a run.
    i_range_disp = 1'b0;
    i_speed_disp = 1'b0;
    i_start_stop = 1'b1;
    i_rst        = 1'b0;
    repeat (3) step();
    chk("reset2 best", o_best, 32'd0);
    i_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (o_state != 3'd0) bad++;
    end
    chk("held high stays idle", 32'(bad), 32'd0);
    i_start_stop = 1'b0;
    repeat (12) step();
    i_start_stop = 1'b1;
    wait_state(3'd1, 20, "low then high arms", n);
    i_range_disp = 1'b1;
    i_speed_disp = 1'b1;
    wait_state(3'd2, 20, "reset run entry", n);
    chk("both switches in run", 32'(o_disp_sel), 32'd0);
    chk("reset run en", 32'(o_cnt_en), 32'd1);

    // Asynchronous reset mid-cycle.
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    chk("async reset en", 32'(o_cnt_en), 32'd0);
    chk("async reset state", 32'(o_state), 32'd0);
    chk("async reset best", o_best, 32'd0);
    i_rst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
